// File: rtl/spif_pkg.sv
// Shared packet-format constants and serialiser state type for the SpiNNaker
// interface TX paths.
package spif_pkg;

  localparam int PACKET_BITS = 72;
  localparam int WORD_BITS   = 32;
  localparam int HDR_BITS    = 8;
  localparam int KEY_LSB     = 8;
  localparam int PAYLOAD_LSB = 40;
  localparam int HDR_PLD_BIT = 1;
  localparam int HDR_PAR_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    KEY  = 2'd2,
    PLD  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/pkt_parity_gen.sv
// Combinational header rewrite: parity bit chosen so the ones-count over the
// transmitted fields (header, key, payload when present) is odd.
module pkt_parity_gen #(
  parameter int PACKET_BITS = 72,
  parameter bit GEN_PARITY  = 1'b1
) (
  input  logic [PACKET_BITS-1:0] i_pkt,
  output logic [7:0]             o_hdr
);
  import spif_pkg::*;

  logic w_long;
  logic w_rest_par;

  assign w_long = i_pkt[HDR_PLD_BIT];

  // Parity of every transmitted bit except the parity bit itself.
  assign w_rest_par = (^i_pkt[HDR_BITS-1:HDR_PAR_BIT+1])
                    ^ (^i_pkt[PAYLOAD_LSB-1:KEY_LSB])
                    ^ (w_long & (^i_pkt[PACKET_BITS-1:PAYLOAD_LSB]));

  always_comb begin
    o_hdr = i_pkt[HDR_BITS-1:0];
    if (GEN_PARITY) begin
      o_hdr[HDR_PAR_BIT] = ~w_rest_par;
    end
  end

endmodule

// File: rtl/pkt_tx_serialiser.sv
// Serialises one routed 72-bit packet into 2 (short) or 3 (long) 32-bit words
// with a registered valid/ready output stage and a completed-packet counter.
module pkt_tx_serialiser #(
  parameter int PACKET_BITS = 72,
  parameter int WORD_BITS   = 32,
  parameter bit GEN_PARITY  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] pkt_in_data_in,
  input  logic                   pkt_in_vld_in,
  output logic                   pkt_in_rdy_out,
  output logic [WORD_BITS-1:0]   word_data_out,
  output logic                   word_last_out,
  output logic                   word_vld_out,
  input  logic                   word_rdy_in,
  output logic [31:0]            pkt_cnt_out,
  output spif_pkg::ser_state_t   dbg_state_out
);
  import spif_pkg::*;

  // Handshakes: a transfer happens on a clock edge where valid && ready.
  // Once word_vld_out is high, data/last hold until word_rdy_in is seen.

  ser_state_t             r_state, w_nxt_state;
  logic                   r_long;
  logic [WORD_BITS-1:0]   r_key, r_pld;
  logic [WORD_BITS-1:0]   r_word_data, w_nxt_data;
  logic                   r_word_last, w_nxt_last;
  logic                   r_word_vld, w_nxt_vld;
  logic [31:0]            r_cnt;
  logic [7:0]             w_hdr;
  logic                   w_hs, w_done, w_accept;

  pkt_parity_gen #(
    .PACKET_BITS (PACKET_BITS),
    .GEN_PARITY  (GEN_PARITY)
  ) u_parity (
    .i_pkt (pkt_in_data_in),
    .o_hdr (w_hdr)
  );

  always_comb begin
    w_hs           = r_word_vld && word_rdy_in;
    w_done         = w_hs && r_word_last;
    pkt_in_rdy_out = reset && ((r_state == IDLE) || w_done);
    w_accept       = pkt_in_vld_in && pkt_in_rdy_out;
    w_nxt_state    = r_state;
    w_nxt_data     = r_word_data;
    w_nxt_last     = r_word_last;
    w_nxt_vld      = r_word_vld;

    case (r_state)
      HDR: begin
        if (w_hs) begin
          w_nxt_state = KEY;
          w_nxt_data  = r_key;
          w_nxt_last  = !r_long;
        end
      end
      KEY: begin
        if (w_hs && r_long) begin
          w_nxt_state = PLD;
          w_nxt_data  = r_pld;
          w_nxt_last  = 1'b1;
        end
      end
      default: ;
    endcase

    // Last word leaving: go idle unless the next packet is taken this cycle.
    if (w_done) begin
      w_nxt_state = IDLE;
      w_nxt_vld   = 1'b0;
      w_nxt_last  = 1'b0;
    end

    if (w_accept) begin
      w_nxt_state = HDR;
      w_nxt_data  = {{(WORD_BITS-8){1'b0}}, w_hdr};
      w_nxt_last  = 1'b0;
      w_nxt_vld   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_word_data <= '0;
      r_word_last <= 1'b0;
      r_word_vld  <= 1'b0;
      r_cnt       <= '0;
      r_long      <= 1'b0;
      r_key       <= '0;
      r_pld       <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_word_data <= w_nxt_data;
      r_word_last <= w_nxt_last;
      r_word_vld  <= w_nxt_vld;
      if (w_done) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_accept) begin
        r_long <= pkt_in_data_in[HDR_PLD_BIT];
        r_key  <= pkt_in_data_in[PAYLOAD_LSB-1:KEY_LSB];
        r_pld  <= pkt_in_data_in[PACKET_BITS-1:PAYLOAD_LSB];
      end
    end
  end

  assign word_data_out = r_word_data;
  assign word_last_out = r_word_last;
  assign word_vld_out  = r_word_vld;
  assign pkt_cnt_out   = r_cnt;
  assign dbg_state_out = r_state;

endmodule

// File: tb/tb_pkt_tx_serialiser.sv
// Randomised bench for pkt_tx_serialiser: two instances (parity on/off) share
// stimulus and are checked against a word-queue reference model.
module tb_pkt_tx_serialiser;
  import spif_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] pkt_in_data_in;
  logic        pkt_in_vld_in;
  logic        word_rdy_in;

  logic        rdy1, last1, vld1, rdy0, last0, vld0;
  logic [31:0] data1, cnt1, data0, cnt0;
  ser_state_t  dbg1, dbg0;

  int n_vec = 0;
  int n_err = 0;
  int rdy_mode = 0;
  bit mon_en = 0;

  logic [32:0] exp_q[$];
  logic [32:0] exp0_q[$];
  logic [31:0] model_cnt = 0;

  always #5 clk = ~clk;

  pkt_tx_serialiser #(.GEN_PARITY(1'b1)) dut (
    .clk(clk), .reset(reset), .pkt_in_data_in(pkt_in_data_in),
    .pkt_in_vld_in(pkt_in_vld_in), .pkt_in_rdy_out(rdy1),
    .word_data_out(data1), .word_last_out(last1), .word_vld_out(vld1),
    .word_rdy_in(word_rdy_in), .pkt_cnt_out(cnt1), .dbg_state_out(dbg1)
  );

  pkt_tx_serialiser #(.GEN_PARITY(1'b0)) dut_nopar (
    .clk(clk), .reset(reset), .pkt_in_data_in(pkt_in_data_in),
    .pkt_in_vld_in(pkt_in_vld_in), .pkt_in_rdy_out(rdy0),
    .word_data_out(data0), .word_last_out(last0), .word_vld_out(vld0),
    .word_rdy_in(word_rdy_in), .pkt_cnt_out(cnt0), .dbg_state_out(dbg0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference header: parity bit makes the transmitted ones-count odd.
  function automatic logic [7:0] model_hdr(input logic [71:0] p, input bit gen);
    logic [7:0] h;
    int n;
    h = p[7:0];
    if (gen) begin
      n = $countones(p[7:1]) + $countones(p[39:8]);
      if (p[1]) n = n + $countones(p[71:40]);
      h[0] = (n % 2 == 0);
    end
    return h;
  endfunction

  function automatic void push_pkt(input logic [71:0] p);
    exp_q.push_back({1'b0, 24'h0, model_hdr(p, 1'b1)});
    exp0_q.push_back({1'b0, 24'h0, model_hdr(p, 1'b0)});
    exp_q.push_back({~p[1], p[39:8]});
    exp0_q.push_back({~p[1], p[39:8]});
    if (p[1]) begin
      exp_q.push_back({1'b1, p[71:40]});
      exp0_q.push_back({1'b1, p[71:40]});
    end
  endfunction

  // Scoreboard/monitor, sampling on the falling edge.
  bit          stall_prev = 0;
  logic [31:0] prev_d1, prev_d0;
  logic        prev_l1, prev_l0;

  always @(negedge clk) begin
    logic exp_rdy;
    if (mon_en) begin
      exp_rdy = reset && (exp_q.size() == 0 || (exp_q.size() == 1 && word_rdy_in));
      check("in_rdy", rdy1, exp_rdy);
      check("in_rdy_nopar", rdy0, exp_rdy);
      check("word_vld", vld1, exp_q.size() != 0);
      check("word_vld_nopar", vld0, exp0_q.size() != 0);
      check("pkt_cnt", cnt1, model_cnt);
      check("pkt_cnt_nopar", cnt0, model_cnt);
      if (stall_prev) begin
        check("stall_data", data1, prev_d1);
        check("stall_last", last1, prev_l1);
        check("stall_data_nopar", data0, prev_d0);
        check("stall_last_nopar", last0, prev_l0);
      end
      if (exp_q.size() != 0) begin
        check("word_data", data1, exp_q[0][31:0]);
        check("word_last", last1, exp_q[0][32]);
        check("word_data_nopar", data0, exp0_q[0][31:0]);
        check("word_last_nopar", last0, exp0_q[0][32]);
      end
      stall_prev = reset && (exp_q.size() != 0) && !word_rdy_in;
      prev_d1 = data1; prev_l1 = last1;
      prev_d0 = data0; prev_l0 = last0;
      if (!reset) begin
        exp_q.delete();
        exp0_q.delete();
        model_cnt = 0;
      end else begin
        if (exp_q.size() != 0 && word_rdy_in) begin
          if (exp_q[0][32]) model_cnt = model_cnt + 1;
          void'(exp_q.pop_front());
          void'(exp0_q.pop_front());
        end
        if (pkt_in_vld_in && exp_rdy) push_pkt(pkt_in_data_in);
      end
    end
  end

  // Output-ready driver: 0 = held high, 1 = toggling, 2 = random.
  initial begin
    word_rdy_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: word_rdy_in = 1'b1;
        1: word_rdy_in = ~word_rdy_in;
        default: word_rdy_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Presents a packet and returns just after the edge that accepted it.
  task automatic send_pkt(input logic [71:0] p);
    bit got = 0;
    pkt_in_data_in = p;
    pkt_in_vld_in  = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rdy1) got = 1;
      @(posedge clk);
      #1;
    end
    check("accept_wait", got, 1'b1);
  endtask

  task automatic drain();
    bit empty = 0;
    pkt_in_vld_in = 1'b0;
    for (int i = 0; i < 200 && !empty; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) empty = 1;
    end
    check("drain_wait", empty, 1'b1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] rand_pkt();
    return {$urandom, $urandom, 8'($urandom_range(0, 255))};
  endfunction

  initial begin
    logic [31:0] base;
    bit at_key;
    reset = 1'b0;
    pkt_in_vld_in = 1'b0;
    pkt_in_data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", vld1, 1'b0);
    check("rst_last", last1, 1'b0);
    check("rst_data", data1, 32'h0);
    check("rst_cnt", cnt1, 32'h0);
    check("rst_in_rdy", rdy1, 1'b0);
    check("rst_state", 64'(dbg1), 64'(IDLE));
    check("rst_data_nopar", data0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1;

    // Directed short and long packets; nopar instance sees hdr unchanged.
    send_pkt({32'h0, 32'h0000_0100, 8'h00});
    pkt_in_vld_in = 1'b0;
    drain();
    send_pkt({32'h1, 32'hFFFF_FFFF, 8'h02});
    pkt_in_vld_in = 1'b0;
    drain();
    check("cnt_after_directed", cnt1, 32'd2);

    // Ten back-to-back short packets with valid and ready held high.
    base = model_cnt;
    for (int i = 0; i < 10; i++) begin
      logic [71:0] p;
      p = rand_pkt();
      p[1] = 1'b0;
      send_pkt(p);
    end
    drain();
    check("burst_cnt", cnt1, base + 32'd10);

    // Long packet with ready toggling every cycle.
    rdy_mode = 1;
    send_pkt({32'hA5A5_0001, 32'h1234_5678, 8'h06});
    pkt_in_vld_in = 1'b0;
    drain();
    rdy_mode = 0;

    // Reset while the key word is on the output.
    send_pkt({32'hCAFE_F00D, 32'hDEAD_BEEF, 8'h02});
    pkt_in_vld_in = 1'b0;
    at_key = 0;
    for (int i = 0; i < 20 && !at_key; i++) begin
      if (dbg1 == KEY) at_key = 1;
      else begin @(posedge clk); #1; end
    end
    check("reached_key", at_key, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("cnt_after_midreset", cnt1, 32'h0);
    send_pkt({32'h0, 32'h0000_0F0F, 8'h10});
    pkt_in_vld_in = 1'b0;
    drain();

    // Randomised traffic with random gaps and random output ready.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        pkt_in_vld_in = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      send_pkt(rand_pkt());
    end
    rdy_mode = 0;
    drain();
    check("cnt_final", cnt1, model_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
